// File: rtl/trap_pkg.sv
// Shared encodings for machine-mode trap sequencing: privilege levels, cause codes, FSM states.
package trap_pkg;
    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam logic [3:0] ECALL_U = 4'd8;
    localparam logic [3:0] ECALL_M = 4'd11;
    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_SAVE,
        ST_REDIRECT,
        ST_RETURN
    } trap_state_e;

    // The reserved privilege encoding falls back to user mode on MRET.
    function automatic logic [1:0] legalizePriv(input logic [1:0] p);
        return (p == 2'b10) ? PRIV_U : p;
    endfunction
endpackage

// File: rtl/trap_irq_prio.sv
// Fixed-priority encoder for pending machine interrupts: external > software > timer.
module trap_irq_prio
    import trap_pkg::*;
(
    input  logic [2:0] irqPending,
    output logic       valid,
    output logic [3:0] code
);
    always_comb begin
        valid = |irqPending;
        code  = '0;
        if (irqPending[2])      code = IRQ_MEI;
        else if (irqPending[0]) code = IRQ_MSI;
        else if (irqPending[1]) code = IRQ_MTI;
    end
endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry / MRET sequencer: stalls and flushes the pipe, writes trap CSRs, redirects fetch.
// Optional TRAP_MTVAL_EN: when defined, mtval carries the exception's trap value; otherwise it is tied to 0.
module trap_controller
    import trap_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_excValid,
    input  logic [3:0]      i_excCause,
    input  logic [XLEN-1:0] i_excPc,
    input  logic [XLEN-1:0] i_excTval,
    input  logic            i_mret,
    input  logic [2:0]      i_irqPending,
    input  logic [XLEN-1:0] i_curPc,
    input  logic            i_mstatusMIE,
    input  logic            i_mstatusMPIE,
    input  logic [1:0]      i_mstatusMPP,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    output logic            o_stall,
    output logic            o_flush,
    output logic            o_csrWe,
    output logic [XLEN-1:0] o_mepc,
    output logic [XLEN-1:0] o_mcause,
    output logic [XLEN-1:0] o_mtval,
    output logic            o_mstatusMIE,
    output logic            o_mstatusMPIE,
    output logic [1:0]      o_mstatusMPP,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirectPc,
    output logic [1:0]      o_privMode
);
    trap_state_e     state;
    logic [3:0]      cnt;
    logic            isIrq;
    logic [3:0]      code;
    logic [XLEN-1:0] epc;
    logic            savedMie;
    logic [1:0]      retPriv;
    logic            irqValid;
    logic [3:0]      irqCode;
    logic            irqEn;
    logic [XLEN-1:0] trapVector;

    trap_irq_prio uPrio (
        .irqPending(i_irqPending),
        .valid     (irqValid),
        .code      (irqCode)
    );

    // Interrupts are always taken below M; in M they need the global enable.
    assign irqEn = i_mstatusMIE || (o_privMode != PRIV_M);
    assign trapVector = {i_mtvec[XLEN-1:2], 2'b00} +
        (((i_mtvec[1:0] == MTVEC_VECTORED) && isIrq) ? XLEN'({code, 2'b00}) : '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            isIrq         <= 1'b0;
            code          <= '0;
            epc           <= '0;
            savedMie      <= 1'b0;
            retPriv       <= PRIV_M;
            o_stall       <= 1'b0;
            o_flush       <= 1'b0;
            o_csrWe       <= 1'b0;
            o_mepc        <= '0;
            o_mcause      <= '0;
            o_mstatusMIE  <= 1'b0;
            o_mstatusMPIE <= 1'b0;
            o_mstatusMPP  <= '0;
            o_redirect    <= 1'b0;
            o_redirectPc  <= '0;
            o_privMode    <= PRIV_M;
        end else begin
            o_stall       <= 1'b0;
            o_flush       <= 1'b0;
            o_csrWe       <= 1'b0;
            o_mepc        <= '0;
            o_mcause      <= '0;
            o_mstatusMIE  <= 1'b0;
            o_mstatusMPIE <= 1'b0;
            o_mstatusMPP  <= '0;
            o_redirect    <= 1'b0;
            o_redirectPc  <= '0;
            case (state)
                ST_IDLE: begin
                    if (i_excValid || (irqValid && irqEn)) begin
                        isIrq    <= !i_excValid;
                        code     <= i_excValid ? i_excCause : irqCode;
                        epc      <= i_excValid ? i_excPc : i_curPc;
                        savedMie <= i_mstatusMIE;
                        cnt      <= 4'(FLUSH_CYCLES - 1);
                        state    <= ST_FLUSH;
                        o_stall  <= 1'b1;
                        o_flush  <= 1'b1;
                    end else if (i_mret) begin
                        retPriv       <= legalizePriv(i_mstatusMPP);
                        state         <= ST_RETURN;
                        o_csrWe       <= 1'b1;
                        o_flush       <= 1'b1;
                        o_stall       <= 1'b1;
                        o_redirect    <= 1'b1;
                        o_redirectPc  <= i_mepc;
                        o_mstatusMIE  <= i_mstatusMPIE;
                        o_mstatusMPIE <= 1'b1;
                        o_mstatusMPP  <= PRIV_U;
                    end
                end
                ST_FLUSH: begin
                    o_stall <= 1'b1;
                    if (cnt == '0) begin
                        state         <= ST_SAVE;
                        o_csrWe       <= 1'b1;
                        o_mepc        <= {epc[XLEN-1:2], 2'b00};
                        o_mcause      <= {isIrq, {(XLEN-5){1'b0}}, code};
                        o_mstatusMPIE <= savedMie;
                        o_mstatusMPP  <= o_privMode;
                    end else begin
                        cnt     <= cnt - 4'd1;
                        o_flush <= 1'b1;
                    end
                end
                ST_SAVE: begin
                    o_privMode   <= PRIV_M;
                    state        <= ST_REDIRECT;
                    o_redirect   <= 1'b1;
                    o_stall      <= 1'b1;
                    o_redirectPc <= trapVector;
                end
                ST_REDIRECT: state <= ST_IDLE;
                ST_RETURN: begin
                    o_privMode <= retPriv;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TRAP_MTVAL_EN
    logic [XLEN-1:0] tvalQ;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tvalQ   <= '0;
            o_mtval <= '0;
        end else begin
            o_mtval <= '0;
            if (state == ST_IDLE) tvalQ <= i_excValid ? i_excTval : '0;
            if (state == ST_FLUSH && cnt == '0) o_mtval <= tvalQ;
        end
    end
`else
    logic unusedTval;
    assign unusedTval = ^i_excTval;
    assign o_mtval    = '0;
`endif
endmodule

// File: tb/tb_trap_controller.sv
// Directed table-driven bench for trap_controller plus a hand-written reset-during-SAVE sequence.
module tb_trap_controller;
    localparam int XLEN = 32;
    localparam int FC   = 2;

    typedef struct packed {
        logic        excValid;
        logic [3:0]  cause;
        logic [31:0] pc;
        logic [31:0] tval;
        logic        mret;
        logic [2:0]  irq;
        logic [31:0] curPc;
        logic        mie;
        logic        mpie;
        logic [1:0]  mpp;
        logic [31:0] mtvec;
        logic [31:0] mepc;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        csrWe;
        logic        redirect;
        logic [1:0]  priv;
        logic        mie;
        logic        mpie;
        logic [1:0]  mpp;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic [31:0] rpc;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } row_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_excValid, i_mret, i_mstatusMIE, i_mstatusMPIE;
    logic [3:0] i_excCause;
    logic [2:0] i_irqPending;
    logic [1:0] i_mstatusMPP;
    logic [XLEN-1:0] i_excPc, i_excTval, i_curPc, i_mtvec, i_mepc;
    logic o_stall, o_flush, o_csrWe, o_mstatusMIE, o_mstatusMPIE, o_redirect;
    logic [1:0] o_mstatusMPP, o_privMode;
    logic [XLEN-1:0] o_mepc, o_mcause, o_mtval, o_redirectPc;

    int nChecks = 0;
    int nFail   = 0;
    row_t rows[$];

    trap_controller #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_excValid(i_excValid), .i_excCause(i_excCause), .i_excPc(i_excPc), .i_excTval(i_excTval),
        .i_mret(i_mret), .i_irqPending(i_irqPending), .i_curPc(i_curPc),
        .i_mstatusMIE(i_mstatusMIE), .i_mstatusMPIE(i_mstatusMPIE), .i_mstatusMPP(i_mstatusMPP),
        .i_mtvec(i_mtvec), .i_mepc(i_mepc),
        .o_stall(o_stall), .o_flush(o_flush), .o_csrWe(o_csrWe),
        .o_mepc(o_mepc), .o_mcause(o_mcause), .o_mtval(o_mtval),
        .o_mstatusMIE(o_mstatusMIE), .o_mstatusMPIE(o_mstatusMPIE), .o_mstatusMPP(o_mstatusMPP),
        .o_redirect(o_redirect), .o_redirectPc(o_redirectPc), .o_privMode(o_privMode)
    );

    always #5 i_clk = ~i_clk;

    function automatic in_t inIdle(logic mie, logic [31:0] mtvec);
        in_t x = '0;
        x.mie   = mie;
        x.mtvec = mtvec;
        return x;
    endfunction

    function automatic in_t inExc(logic [3:0] c, logic [31:0] pc, logic [31:0] tv, logic mie, logic [31:0] mtvec);
        in_t x = inIdle(mie, mtvec);
        x.excValid = 1'b1; x.cause = c; x.pc = pc; x.tval = tv;
        return x;
    endfunction

    function automatic in_t inIrq(logic [2:0] irq, logic [31:0] cpc, logic mie, logic [31:0] mtvec);
        in_t x = inIdle(mie, mtvec);
        x.irq = irq; x.curPc = cpc;
        return x;
    endfunction

    function automatic in_t inMret(logic mpie, logic [1:0] mpp, logic [31:0] mepc, logic mie);
        in_t x = inIdle(mie, 32'h800);
        x.mret = 1'b1; x.mpie = mpie; x.mpp = mpp; x.mepc = mepc;
        return x;
    endfunction

    function automatic logic [31:0] expTval(logic [31:0] t);
`ifdef TRAP_MTVAL_EN
        return t;
`else
        return (t & 32'h0);
`endif
    endfunction

    function automatic out_t oIdle(logic [1:0] priv);
        out_t o = '0;
        o.priv = priv;
        return o;
    endfunction

    function automatic out_t oFlush(logic [1:0] priv);
        out_t o = oIdle(priv);
        o.stall = 1'b1; o.flush = 1'b1;
        return o;
    endfunction

    function automatic out_t oSave(logic [31:0] mepc, logic [31:0] mcause, logic [31:0] tv,
                                   logic mpie, logic [1:0] mpp, logic [1:0] priv);
        out_t o = oIdle(priv);
        o.stall = 1'b1; o.csrWe = 1'b1; o.mepc = mepc; o.mcause = mcause;
        o.mtval = expTval(tv); o.mpie = mpie; o.mpp = mpp;
        return o;
    endfunction

    function automatic out_t oRedir(logic [31:0] pc);
        out_t o = oIdle(2'd3);
        o.stall = 1'b1; o.redirect = 1'b1; o.rpc = pc;
        return o;
    endfunction

    function automatic out_t oRet(logic [31:0] pc, logic mie, logic [1:0] priv);
        out_t o = oIdle(priv);
        o.stall = 1'b1; o.flush = 1'b1; o.csrWe = 1'b1; o.redirect = 1'b1;
        o.rpc = pc; o.mie = mie; o.mpie = 1'b1; o.mpp = 2'd0;
        return o;
    endfunction

    task automatic push(string name, in_t in, out_t exp);
        row_t r;
        r.name = name; r.in = in; r.exp = exp;
        rows.push_back(r);
    endtask

    // Full trap: accept, flush cycles, SAVE, REDIRECT, back to IDLE in M-mode.
    task automatic trapSeq(string name, in_t trig, in_t idle, logic [1:0] priv,
                           logic [31:0] mepc, logic [31:0] mcause, logic [31:0] tv,
                           logic mpie, logic [1:0] mpp, logic [31:0] rpc);
        push({name, "_flush0"}, trig, oFlush(priv));
        for (int i = 1; i < FC; i++) push({name, "_flushN"}, idle, oFlush(priv));
        push({name, "_save"}, idle, oSave(mepc, mcause, tv, mpie, mpp, priv));
        push({name, "_redir"}, idle, oRedir(rpc));
        push({name, "_idle"}, idle, oIdle(2'd3));
    endtask

    task automatic drive(in_t x);
        i_excValid = x.excValid; i_excCause = x.cause; i_excPc = x.pc; i_excTval = x.tval;
        i_mret = x.mret; i_irqPending = x.irq; i_curPc = x.curPc;
        i_mstatusMIE = x.mie; i_mstatusMPIE = x.mpie; i_mstatusMPP = x.mpp;
        i_mtvec = x.mtvec; i_mepc = x.mepc;
    endtask

    task automatic check(string name, out_t exp);
        out_t act;
        act = {o_stall, o_flush, o_csrWe, o_redirect, o_privMode, o_mstatusMIE, o_mstatusMPIE,
               o_mstatusMPP, o_mepc, o_mcause, o_mtval, o_redirectPc};
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        in_t sim;
        // Illegal instruction from M-mode, direct mtvec.
        trapSeq("illegal", inExc(4'd2, 32'h100, 32'hDEAD, 1'b1, 32'h800), inIdle(1'b1, 32'h800),
                2'd3, 32'h100, 32'h2, 32'hDEAD, 1'b1, 2'd3, 32'h800);
        // Vectored timer interrupt.
        trapSeq("timer", inIrq(3'b010, 32'h204, 1'b1, 32'h801), inIdle(1'b1, 32'h801),
                2'd3, 32'h204, 32'h80000007, 32'h0, 1'b1, 2'd3, 32'h81C);
        // Exception, interrupt and MRET together: exception wins, no vector offset.
        sim = inExc(4'd5, 32'h300, 32'h44, 1'b1, 32'h801);
        sim.irq = 3'b111; sim.mret = 1'b1; sim.curPc = 32'h999; sim.mpp = 2'd0; sim.mepc = 32'h5000;
        trapSeq("simul", sim, inIdle(1'b1, 32'h801),
                2'd3, 32'h300, 32'h5, 32'h44, 1'b1, 2'd3, 32'h800);
        push("simul_noret", inIdle(1'b1, 32'h801), oIdle(2'd3));
        // MRET to U, then ecall from U with a misaligned pc.
        push("mret_u", inMret(1'b1, 2'd0, 32'h400, 1'b0), oRet(32'h400, 1'b1, 2'd3));
        push("mret_u_priv", inIdle(1'b0, 32'h800), oIdle(2'd0));
        trapSeq("ecall_u", inExc(4'd8, 32'h2003, 32'h0, 1'b0, 32'h800), inIdle(1'b0, 32'h800),
                2'd0, 32'h2000, 32'h8, 32'h0, 1'b0, 2'd0, 32'h800);
        // External interrupt masked in M-mode, taken once in U-mode.
        push("masked0", inIrq(3'b100, 32'h500, 1'b0, 32'h801), oIdle(2'd3));
        push("masked1", inIrq(3'b100, 32'h500, 1'b0, 32'h801), oIdle(2'd3));
        push("mret_u2", inMret(1'b0, 2'd0, 32'h480, 1'b0), oRet(32'h480, 1'b0, 2'd3));
        push("mret_u2_priv", inIdle(1'b0, 32'h801), oIdle(2'd0));
        trapSeq("meip_u", inIrq(3'b100, 32'h500, 1'b0, 32'h801), inIdle(1'b0, 32'h801),
                2'd0, 32'h500, 32'h8000000B, 32'h0, 1'b0, 2'd0, 32'h82C);
        // Reserved MPP maps to U; then msip beats mtip.
        push("mret_rsvd", inMret(1'b1, 2'b10, 32'h600, 1'b0), oRet(32'h600, 1'b1, 2'd3));
        push("mret_rsvd_priv", inIdle(1'b0, 32'h801), oIdle(2'd0));
        trapSeq("msip", inIrq(3'b011, 32'h608, 1'b0, 32'h801), inIdle(1'b0, 32'h801),
                2'd0, 32'h608, 32'h80000003, 32'h0, 1'b0, 2'd0, 32'h80C);

        drive(inIdle(1'b0, 32'h800));
        repeat (2) @(posedge i_clk);
        #1 check("reset_state", oIdle(2'd3));
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1 check("post_reset_idle", oIdle(2'd3));

        foreach (rows[i]) begin
            drive(rows[i].in);
            @(posedge i_clk);
            #1 check(rows[i].name, rows[i].exp);
        end

        // Reset asserted while SAVE is on the outputs.
        drive(inMret(1'b0, 2'd0, 32'h700, 1'b0));
        @(posedge i_clk);
        #1 drive(inIdle(1'b0, 32'h800));
        @(posedge i_clk);
        #1 check("rst_seq_priv_u", oIdle(2'd0));
        drive(inExc(4'd8, 32'h710, 32'h0, 1'b0, 32'h800));
        @(posedge i_clk);
        #1 drive(inIdle(1'b0, 32'h800));
        repeat (FC) @(posedge i_clk);
        #1 check("rst_seq_save", oSave(32'h710, 32'h8, 32'h0, 1'b0, 2'd0, 2'd0));
        i_rst = 1'b1;
        #1 check("rst_mid_save", oIdle(2'd3));
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk);
            #1 check("rst_after_idle", oIdle(2'd3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Sequences machine-mode trap entry and MRET return for the RV32 core.
- Takes the resolved exception cause from the decode-stage cause logic, pending interrupts and MRET requests.
- Stalls and flushes the pipeline, issues CSR writes (mepc/mcause/mtval/mstatus), owns the current privilege mode, and redirects fetch.
- Sits beside the CSR file and drives the PC-select mux.

Parameters:
- XLEN, 32, data/address width.
- FLUSH_CYCLES, 2, cycles flush is held (1..15).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_excValid  in  1  exception reported by ID stage
- i_excCause  in  4  resolved cause (ecall already offset by privilege)
- i_excPc  in  XLEN  PC of faulting instruction
- i_excTval  in  XLEN  trap value
- i_mret  in  1  MRET retiring in ID
- i_irqPending  in  3  {meip, mtip, msip}, already masked by mie
- i_curPc  in  XLEN  PC of next instruction to resume (interrupt mepc)
- i_mstatusMIE  in  1
- i_mstatusMPIE  in  1
- i_mstatusMPP  in  2
- i_mtvec  in  XLEN  [1:0]=mode
- i_mepc  in  XLEN
- o_stall  out  1  hold IF/ID
- o_flush  out  1  squash IF/ID/EX
- o_csrWe  out  1  strobe for all following CSR outputs
- o_mepc, o_mcause, o_mtval  out  XLEN
- o_mstatusMIE, o_mstatusMPIE  out  1
- o_mstatusMPP  out  2
- o_redirect  out  1  one-cycle PC load
- o_redirectPc  out  XLEN
- o_privMode  out  2  current privilege

Behaviour:
- Reset (async, i_rst=1): state IDLE, o_privMode=2'b11; all other outputs 0; flush counter 0.
- States: IDLE, FLUSH, SAVE, REDIRECT, RETURN.
- IDLE, priority:
  - i_excValid → latch cause/pc/tval, isIrq=0, go FLUSH.
  - Else, if i_mstatusMIE or o_privMode != 3, any i_irqPending bit → latch isIrq=1 and code (meip=11 > msip=3 > mtip=7), epc=i_curPc, tval=0, go FLUSH.
  - Else i_mret → go RETURN.
  - Simultaneous events: the higher one wins; losers are dropped (requesters re-assert).
- FLUSH:
  - o_stall=1, o_flush=1 for exactly FLUSH_CYCLES cycles (counter loaded FLUSH_CYCLES-1, count to 0), then SAVE.
- SAVE, one cycle:
  - o_csrWe=1, o_stall=1.
  - o_mepc = epc with bits[1:0] cleared.
  - o_mcause = {isIrq, 27'b0, code}, widened to XLEN.
  - o_mtval = tval.
  - o_mstatusMPIE = i_mstatusMIE; o_mstatusMIE=0; o_mstatusMPP = o_privMode.
  - o_privMode ← 3 at the clock edge. Go REDIRECT.
- REDIRECT, one cycle:
  - o_redirect=1, o_stall=1.
  - o_redirectPc = {mtvec[XLEN-1:2],2'b00}, plus 4*code when mode==1 and isIrq. Arithmetic is modulo 2^XLEN.
  - Go IDLE.
- RETURN, one cycle:
  - o_csrWe=1, o_flush=1, o_stall=1, o_redirect=1, o_redirectPc=i_mepc.
  - o_mstatusMIE=i_mstatusMPIE; o_mstatusMPIE=1; o_mstatusMPP=2'b00.
  - o_privMode ← i_mstatusMPP, with reserved 2'b10 mapped to 2'b00. Go IDLE.
- Outputs not named in a state are 0. The CSR data outputs are don't-care unless o_csrWe=1 but are driven 0.
- All inputs are ignored outside IDLE. Events arriving mid-sequence are not queued.
- Reset mid-sequence aborts immediately. No partial CSR write is produced after reset is asserted.
- Trap latency, exception accepted to redirect: FLUSH_CYCLES+2 cycles. MRET latency: 1 cycle.

Optional Feature:
- TRAP_MTVAL_EN:
  - Defined: o_mtval carries the latched i_excTval.
  - Undefined: the tval latch is removed and o_mtval is constant 0 in all states.

Decomposition:
- Shared package (trap_pkg):
  - Privilege encodings PRIV_U=0, PRIV_S=1, PRIV_M=3.
  - Cause codes (ECALL_U=8, ECALL_M=11, IRQ_MSI=3, IRQ_MTI=7, IRQ_MEI=11).
  - State enum.
  - MTVEC_VECTORED=1.
- One natural sub-module: trap_irq_prio, a combinational priority encoder from i_irqPending to {valid, code}.

Test Plan:
- Illegal-instruction exception: i_excValid=1, cause=2, pc=0x100, tval=0xDEAD, mtvec=0x800 → flush for 2 cycles, then SAVE with mepc=0x100, mcause=2, mtval=0xDEAD, MIE 1→0, MPP=3, then redirect to 0x800.
- Vectored timer interrupt: mtvec=0x801, mip={0,1,0}, MIE=1, curPc=0x204 → mcause=0x80000007, mepc=0x204, redirect 0x81C.
- Simultaneous exception, interrupt and MRET in one cycle → exception path only; mcause=exception code, mret ignored.
- MRET from M with MPP=0, MPIE=1 → same cycle o_redirectPc=i_mepc, MIE=1, MPP=0, next cycle o_privMode=0. Then ecall (cause=8) → mcause=8, MPP=0, privMode=3.
- Interrupt masked: privMode=3, MIE=0, meip=1 → stays IDLE with no stall. Same case with privMode=0 → trap taken with code 11.
- Assert i_rst during SAVE → outputs 0 and privMode=3 immediately. After release, stays IDLE until a new event.
